// File: rtl/fp_convert_pipe_pkg.sv
// Shared FPU types: op encodings, rounding modes, per-lane stage-1 record and
// the rounding-increment rule reused by the FMA.
package pkg_opengpu;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        FPU_CVTWS  = 3'd0,
        FPU_CVTWUS = 3'd1,
        FPU_CVTSW  = 3'd2,
        FPU_CVTSWU = 3'd3
    } fpu_op_t;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } fp_rm_t;

    // bits holds the truncated integer magnitude (float->int) or the
    // normalised magnitude (int->float); g/st only matter for float->int.
    typedef struct packed {
        logic        sign;
        logic        nan;
        logic        ovf;
        logic [31:0] bits;
        logic        g;
        logic        st;
        logic [4:0]  lz;
        logic        zero;
    } lane_s1_t;

    // Undefined encodings 5-7 fall through to round-to-nearest-even.
    function automatic logic rnd_inc(input logic [2:0] rm, input logic g,
                                     input logic s, input logic l, input logic sg);
        case (rm)
            RM_RTZ:  return 1'b0;
            RM_RDN:  return sg & (g | s);
            RM_RUP:  return ~sg & (g | s);
            RM_RMM:  return g;
            default: return g & (s | l);
        endcase
    endfunction

endpackage

// File: rtl/fp_convert_pipe_lzc32.sv
// 32-bit leading-zero counter with an all-zero flag.
module fp_lzc32 (
    input  logic [31:0] i_data,
    output logic [4:0]  o_cnt,
    output logic        o_zero
);

    always_comb begin : b_scan
        logic found;
        found = 1'b0;
        o_cnt = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (!found && i_data[i]) begin
                o_cnt = 5'(31 - i);
                found = 1'b1;
            end
        end
    end

    assign o_zero = ~|i_data;

endmodule

// File: rtl/fp_convert_pipe.sv
// Two-stage, multi-lane float<->int32 converter with valid/ready backpressure,
// IEEE rounding modes and per-lane invalid/inexact flags.
module fp_convert_pipe
    import pkg_opengpu::*;
#(
    parameter int LANES     = 4,
    parameter int TAG_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  fpu_op_t                       in_op,
    input  logic [2:0]                    in_rm,
    input  logic [LANES-1:0]              in_mask,
    input  logic [LANES*DATA_WIDTH-1:0]   in_data,
    input  logic [TAG_WIDTH-1:0]          in_tag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*DATA_WIDTH-1:0]   out_data,
    output logic [LANES-1:0]              out_nv,
    output logic [LANES-1:0]              out_nx,
    output logic [TAG_WIDTH-1:0]          out_tag
);

    logic                        r_vld_p1, r_vld_p2;
    logic                        w_s1_en, w_s2_en;
    fpu_op_t                     r_op_p1;
    logic [2:0]                  r_rm_p1;
    logic [LANES-1:0]            r_mask_p1;
    logic [TAG_WIDTH-1:0]        r_tag_p1;
    lane_s1_t [LANES-1:0]        w_s1_all, r_s1_p1;
    logic [LANES*DATA_WIDTH-1:0] w_res_all, r_data_p2;
    logic [LANES-1:0]            w_nv_all, w_nx_all, r_nv_p2, r_nx_p2;
    logic [TAG_WIDTH-1:0]        r_tag_p2;

    assign w_s2_en  = !r_vld_p2 || out_ready;
    assign w_s1_en  = !r_vld_p1 || w_s2_en;
    assign in_ready = w_s1_en;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [31:0] w_x, w_abs, w_norm;
        logic [7:0]  w_e, w_ebias, w_sh;
        logic [23:0] w_m;
        logic [55:0] w_wide, w_fix;
        logic        w_lost, w_isgn, w_zero;
        logic [4:0]  w_lz;
        lane_s1_t    w_s1, w_q;
        logic [32:0] w_mag;
        logic [24:0] w_mant;
        logic [7:0]  w_exp;
        logic [22:0] w_frac;
        logic        w_fg, w_fs, w_inc_f, w_inc_i;
        logic [31:0] w_res;
        logic        w_nv, w_nx;

        // S1: value * 2^24 as a 56-bit fixed-point word; shifted-out bits fold into sticky
        assign w_x     = in_data[DATA_WIDTH*l +: DATA_WIDTH];
        assign w_e     = w_x[30:23];
        assign w_m     = {|w_e, w_x[22:0]};
        assign w_ebias = (w_e == 8'd0) ? 8'd1 : w_e;
        assign w_sh    = 8'd158 - w_ebias;
        assign w_wide  = {w_m, 32'b0};
        assign w_fix   = w_wide >> w_sh;
        assign w_lost  = |(w_wide & ~({56{1'b1}} << w_sh));

        assign w_isgn  = (in_op == FPU_CVTSW) && w_x[31];
        assign w_abs   = w_isgn ? (~w_x + 32'd1) : w_x;
        fp_lzc32 u_lzc (.i_data(w_abs), .o_cnt(w_lz), .o_zero(w_zero));
        assign w_norm  = w_abs << w_lz;

        always_comb begin
            w_s1 = '0;
            if (in_op == FPU_CVTWS || in_op == FPU_CVTWUS) begin
                w_s1.sign = w_x[31];
                w_s1.nan  = (w_e == 8'hFF) && (w_x[22:0] != 23'd0);
                w_s1.ovf  = (w_e >= 8'd159);
                w_s1.bits = w_fix[55:24];
                w_s1.g    = w_fix[23];
                w_s1.st   = (|w_fix[22:0]) | w_lost;
            end else begin
                w_s1.sign = w_isgn;
                w_s1.bits = w_norm;
                w_s1.lz   = w_lz;
                w_s1.zero = w_zero;
            end
        end
        assign w_s1_all[l] = w_s1;

        // S2: round, range-check and pack
        assign w_q     = r_s1_p1[l];
        assign w_inc_i = rnd_inc(r_rm_p1, w_q.g, w_q.st, w_q.bits[0], w_q.sign);
        assign w_mag   = {1'b0, w_q.bits} + {32'b0, w_inc_i};
        assign w_fg    = w_q.bits[7];
        assign w_fs    = |w_q.bits[6:0];
        assign w_inc_f = rnd_inc(r_rm_p1, w_fg, w_fs, w_q.bits[8], w_q.sign);
        assign w_mant  = {1'b0, w_q.bits[31:8]} + {24'b0, w_inc_f};
        assign w_exp   = 8'd158 - {3'b0, w_q.lz} + {7'b0, w_mant[24]};
        assign w_frac  = w_mant[24] ? 23'd0 : w_mant[22:0];

        always_comb begin
            w_res = 32'd0;
            w_nv  = 1'b0;
            w_nx  = 1'b0;
            if (r_mask_p1[l]) begin
                case (r_op_p1)
                    FPU_CVTWS: begin
                        if (w_q.nan || (!w_q.sign && (w_q.ovf || w_mag > 33'h07FFFFFFF))) begin
                            w_res = 32'h7FFFFFFF;
                            w_nv  = 1'b1;
                        end else if (w_q.sign && (w_q.ovf || w_mag > 33'h080000000)) begin
                            w_res = 32'h80000000;
                            w_nv  = 1'b1;
                        end else begin
                            w_res = w_q.sign ? (~w_mag[31:0] + 32'd1) : w_mag[31:0];
                            w_nx  = w_q.g | w_q.st;
                        end
                    end
                    FPU_CVTWUS: begin
                        if (w_q.nan || (!w_q.sign && (w_q.ovf || w_mag[32]))) begin
                            w_res = 32'hFFFFFFFF;
                            w_nv  = 1'b1;
                        end else if (w_q.sign && (w_q.ovf || w_mag != 33'd0)) begin
                            w_nv  = 1'b1;
                        end else begin
                            w_res = w_q.sign ? 32'd0 : w_mag[31:0];
                            w_nx  = w_q.g | w_q.st;
                        end
                    end
                    FPU_CVTSW, FPU_CVTSWU: begin
                        if (!w_q.zero) begin
                            w_res = {w_q.sign, w_exp, w_frac};
                            w_nx  = w_fg | w_fs;
                        end
                    end
                    default: ;
                endcase
            end
        end
        assign w_res_all[DATA_WIDTH*l +: DATA_WIDTH] = w_res;
        assign w_nv_all[l] = w_nv;
        assign w_nx_all[l] = w_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1  <= 1'b0;
            r_vld_p2  <= 1'b0;
            r_data_p2 <= '0;
            r_nv_p2   <= '0;
            r_nx_p2   <= '0;
            r_tag_p2  <= '0;
        end else begin
            if (w_s1_en) r_vld_p1 <= in_valid;
            if (w_s2_en) r_vld_p2 <= r_vld_p1;
            if (w_s2_en && r_vld_p1) begin
                r_data_p2 <= w_res_all;
                r_nv_p2   <= w_nv_all;
                r_nx_p2   <= w_nx_all;
                r_tag_p2  <= r_tag_p1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_s1_en && in_valid) begin
            r_op_p1   <= in_op;
            r_rm_p1   <= in_rm;
            r_mask_p1 <= in_mask;
            r_tag_p1  <= in_tag;
            r_s1_p1   <= w_s1_all;
        end
    end

    assign out_valid = r_vld_p2;
    assign out_data  = r_data_p2;
    assign out_nv    = r_nv_p2;
    assign out_nx    = r_nx_p2;
    assign out_tag   = r_tag_p2;

endmodule

// File: tb/tb_fp_convert_pipe.sv
// Directed bench for fp_convert_pipe: conversion vectors, masking, stall and reset.
module tb_fp_convert_pipe;
    import pkg_opengpu::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready;
    fpu_op_t      in_op;
    logic [2:0]   in_rm;
    logic [3:0]   in_mask, out_nv, out_nx;
    logic [127:0] in_data, out_data;
    logic [7:0]   in_tag, out_tag;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] next_tag = 8'h01;

    fp_convert_pipe #(.LANES(4), .TAG_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rm(in_rm), .in_mask(in_mask), .in_data(in_data),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_nv(out_nv), .out_nx(out_nx), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic issue(input fpu_op_t op, input logic [2:0] rm, input logic [3:0] mask,
                         input logic [127:0] data, input logic [7:0] tag,
                         output logic [127:0] rdata, output logic [3:0] rnv,
                         output logic [3:0] rnx, output logic [7:0] rtag, output int lat);
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_rm = rm; in_mask = mask;
        in_data = data; in_tag = tag; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        rdata = out_data; rnv = out_nv; rnx = out_nx; rtag = out_tag;
    endtask

    task automatic conv(input string name, input fpu_op_t op, input logic [2:0] rm,
                        input logic [31:0] x, input logic [31:0] exp,
                        input logic nv, input logic nx);
        logic [127:0] d;
        logic [3:0]   fnv, fnx;
        logic [7:0]   t, tg;
        int           lat;
        tg = next_tag;
        next_tag = next_tag + 8'd1;
        issue(op, rm, 4'hF, {4{x}}, tg, d, fnv, fnx, t, lat);
        check({name, "_lat"}, lat, 2);
        check({name, "_data"}, d, {4{exp}});
        check({name, "_flags"}, {fnv, fnx}, {{4{nv}}, {4{nx}}});
        check({name, "_tag"}, t, tg);
    endtask

    logic [31:0] stall_exp [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                                   32'h40800000, 32'h40A00000, 32'h40C00000};

    task automatic stall_test();
        int acc = 0, ret = 0, first = -1, c = 0;
        while (ret < 6 && c < 40) begin
            @(negedge clk);
            if (out_valid && first < 0) first = c;
            out_ready = !(c >= 3 && c <= 7);
            in_valid  = (acc < 6);
            in_op = FPU_CVTSW; in_rm = 3'd0; in_mask = 4'hF;
            in_data = {4{32'(acc + 1)}};
            in_tag  = 8'hA0 + 8'(acc);
            #1;
            if (c == 3) begin
                check("stall_in_ready_c3", in_ready, 1'b0);
                check("stall_accepted_c3", acc, 3);
            end
            if (out_valid && !out_ready) check("stall_hold_tag", out_tag, 8'hA0 + 8'(ret));
            if (out_valid && out_ready) begin
                check("stall_tag", out_tag, 8'hA0 + 8'(ret));
                check("stall_data", out_data, {4{stall_exp[ret]}});
                ret++;
            end
            if (in_valid && in_ready) acc++;
            c++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stall_first_valid", first, 2);
        check("stall_retired", ret, 6);
    endtask

    task automatic reset_test();
        @(negedge clk);
        in_valid = 1'b1; in_op = FPU_CVTSW; in_rm = 3'd0; in_mask = 4'hF;
        in_data = {4{32'd7}}; in_tag = 8'h11; out_ready = 1'b1;
        @(negedge clk);
        in_data = {4{32'd8}}; in_tag = 8'h22;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 128'd0);
        check("rst_out_tag", out_tag, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        in_valid = 1'b1; in_data = {4{32'd9}}; in_tag = 8'h55;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check("rst_post_valid", out_valid, c == 2);
            if (out_valid) begin
                check("rst_post_tag", out_tag, 8'h55);
                check("rst_post_data", out_data, {4{32'h41100000}});
            end
        end
    endtask

    initial begin
        logic [127:0] d;
        logic [3:0]   fnv, fnx;
        logic [7:0]   t;
        int           lat;

        rst_n = 1'b0; in_valid = 1'b0; in_op = FPU_CVTWS; in_rm = 3'd0;
        in_mask = 4'h0; in_data = '0; in_tag = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_data", out_data, 128'd0);
        check("reset_out_flags", {out_nv, out_nx}, 8'd0);
        check("reset_out_tag", out_tag, 8'd0);
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", in_ready, 1'b1);

        conv("ws_rne_1p5",   FPU_CVTWS,  3'd0, 32'h3FC00000, 32'h00000002, 1'b0, 1'b1);
        conv("ws_rtz_1p5",   FPU_CVTWS,  3'd1, 32'h3FC00000, 32'h00000001, 1'b0, 1'b1);
        conv("ws_rdn_m1p5",  FPU_CVTWS,  3'd2, 32'hBFC00000, 32'hFFFFFFFE, 1'b0, 1'b1);
        conv("ws_rne_2p5",   FPU_CVTWS,  3'd0, 32'h40200000, 32'h00000002, 1'b0, 1'b1);
        conv("ws_rmm_2p5",   FPU_CVTWS,  3'd4, 32'h40200000, 32'h00000003, 1'b0, 1'b1);
        conv("ws_rm7_2p5",   FPU_CVTWS,  3'd7, 32'h40200000, 32'h00000002, 1'b0, 1'b1);
        conv("ws_min_int",   FPU_CVTWS,  3'd0, 32'hCF000000, 32'h80000000, 1'b0, 1'b0);
        conv("ws_2p31",      FPU_CVTWS,  3'd0, 32'h4F000000, 32'h7FFFFFFF, 1'b1, 1'b0);
        conv("ws_nan",       FPU_CVTWS,  3'd0, 32'h7FC00000, 32'h7FFFFFFF, 1'b1, 1'b0);
        conv("ws_ninf",      FPU_CVTWS,  3'd0, 32'hFF800000, 32'h80000000, 1'b1, 1'b0);
        conv("ws_denorm_up", FPU_CVTWS,  3'd3, 32'h00000001, 32'h00000001, 1'b0, 1'b1);
        conv("sw_rne_2p24",  FPU_CVTSW,  3'd0, 32'h01000001, 32'h4B800000, 1'b0, 1'b1);
        conv("sw_rup_2p24",  FPU_CVTSW,  3'd3, 32'h01000001, 32'h4B800001, 1'b0, 1'b1);
        conv("sw_zero",      FPU_CVTSW,  3'd0, 32'h00000000, 32'h00000000, 1'b0, 1'b0);
        conv("sw_m1",        FPU_CVTSW,  3'd0, 32'hFFFFFFFF, 32'hBF800000, 1'b0, 1'b0);
        conv("sw_min_int",   FPU_CVTSW,  3'd0, 32'h80000000, 32'hCF000000, 1'b0, 1'b0);
        conv("swu_max",      FPU_CVTSWU, 3'd0, 32'hFFFFFFFF, 32'h4F800000, 1'b0, 1'b1);
        conv("wus_nan",      FPU_CVTWUS, 3'd0, 32'h7FC00000, 32'hFFFFFFFF, 1'b1, 1'b0);
        conv("wus_m1",       FPU_CVTWUS, 3'd0, 32'hBF800000, 32'h00000000, 1'b1, 1'b0);
        conv("wus_rtz_mq",   FPU_CVTWUS, 3'd1, 32'hBE800000, 32'h00000000, 1'b0, 1'b1);
        conv("wus_rdn_mq",   FPU_CVTWUS, 3'd2, 32'hBE800000, 32'h00000000, 1'b1, 1'b0);
        conv("wus_rne_mh",   FPU_CVTWUS, 3'd0, 32'hBF000000, 32'h00000000, 1'b0, 1'b1);
        conv("wus_2p32",     FPU_CVTWUS, 3'd0, 32'h4F800000, 32'hFFFFFFFF, 1'b1, 1'b0);
        conv("unknown_op",   fpu_op_t'(3'd5), 3'd0, 32'h3FC00000, 32'h00000000, 1'b0, 1'b0);

        issue(FPU_CVTWS, 3'd0, 4'b0101, {4{32'h3F800000}}, 8'h77, d, fnv, fnx, t, lat);
        check("mask_data", d, 128'h00000000_00000001_00000000_00000001);
        check("mask_flags", {fnv, fnx}, 8'd0);
        check("mask_tag", t, 8'h77);

        repeat (3) @(negedge clk);
        stall_test();
        repeat (3) @(negedge clk);
        reset_test();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
